// File: rtl/cdc_fifo_rptr_empty_pkg.sv
// Shared Gray-code helpers for the dual-clock FIFO pointer logic.
// Both sides of the FIFO call these, so they encode and decode pointers the same way.
package cdc_fifo_rptr_empty_pkg;

    localparam int GRAY_MAX_W = 32;

    // Callers zero-extend narrower pointers and truncate the result.
    // Zero upper bits leave the low bits unchanged, so one definition serves any width.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/cdc_fifo_gray_ctr.sv
// Binary and Gray register pair that advances by one when enabled.
// The next-state values are exported so that flag logic can look one edge ahead.
module cdc_fifo_gray_ctr
    import cdc_fifo_rptr_empty_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic [W-2:0] addr_o,
    output logic [W-1:0] gray_o,
    output logic [W-1:0] bin_next_o,
    output logic [W-1:0] gray_next_o
);

    logic [W-1:0] bin_q, bin_d;
    logic [W-1:0] gray_q, gray_d;

    // The binary value rolls over naturally, and the MSB acts as the wrap bit.
    always_comb begin
        bin_d  = bin_q + W'(en_i);
        gray_d = W'(bin2gray(GRAY_MAX_W'(bin_d)));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign addr_o      = bin_q[W-2:0];
    assign gray_o      = gray_q;
    assign bin_next_o  = bin_d;
    assign gray_next_o = gray_d;

endmodule

// File: rtl/cdc_fifo_rptr_empty.sv
// Read-domain pointer, RAM address, empty and almost-empty flags, and occupancy for the dual-clock FIFO.
// Every output is registered on r_clk.
module cdc_fifo_rptr_empty
    import cdc_fifo_rptr_empty_pkg::*;
#(
    parameter int ADDR_SIZE = 4
) (
    input  logic                 r_clk,
    input  logic                 r_rst_n,
    input  logic                 r_inc,
    input  logic [ADDR_SIZE:0]   r_q2_wptr,
    output logic                 r_almost_empty,
    output logic                 r_empty,
    output logic [ADDR_SIZE:0]   r_ptr,
    output logic [ADDR_SIZE-1:0] r_addr,
    output logic [ADDR_SIZE:0]   r_count
);

    localparam int PW = ADDR_SIZE + 1;

    logic          r_pop;
    logic [PW-1:0] r_bin_d;
    logic [PW-1:0] r_gray_d;
    logic [PW-1:0] r_bin_ahead;
    logic [PW-1:0] r_gray_ahead;
    logic [PW-1:0] r_wbin;
    logic          r_empty_d, r_almost_empty_d;
    logic [PW-1:0] r_count_d;
    logic          r_empty_q, r_almost_empty_q;
    logic [PW-1:0] r_count_q;

    assign r_pop = r_inc & ~r_empty_q;

    cdc_fifo_gray_ctr #(
        .W (PW)
    ) u_rptr (
        .clk_i       (r_clk),
        .rst_ni      (r_rst_n),
        .en_i        (r_pop),
        .addr_o      (r_addr),
        .gray_o      (r_ptr),
        .bin_next_o  (r_bin_d),
        .gray_next_o (r_gray_d)
    );

    // Add one at pointer width before Gray-encoding, so that the look-ahead wraps with the pointer.
    always_comb begin
        r_bin_ahead      = r_bin_d + PW'(1);
        r_gray_ahead     = PW'(bin2gray(GRAY_MAX_W'(r_bin_ahead)));
        r_wbin           = PW'(gray2bin(GRAY_MAX_W'(r_q2_wptr)));
        r_empty_d        = (r_gray_d == r_q2_wptr);
        r_almost_empty_d = r_empty_d | (r_gray_ahead == r_q2_wptr);
        r_count_d        = r_wbin - r_bin_d;
    end

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_empty_q        <= 1'b1;
            r_almost_empty_q <= 1'b1;
            r_count_q        <= '0;
        end else begin
            r_empty_q        <= r_empty_d;
            r_almost_empty_q <= r_almost_empty_d;
            r_count_q        <= r_count_d;
        end
    end

    assign r_empty        = r_empty_q;
    assign r_almost_empty = r_almost_empty_q;
    assign r_count        = r_count_q;

endmodule

// File: tb/tb_cdc_fifo_rptr_empty.sv
// Read-side FIFO pointer bench: directed scenarios, then random pops and write-pointer moves.
// The reference is an occupancy model built from whole-number pointers.
module tb_cdc_fifo_rptr_empty;

    logic       r_clk;
    logic       r_rst_n;
    logic       r_inc;
    logic [4:0] r_q2_wptr;
    logic       r_almost_empty;
    logic       r_empty;
    logic [4:0] r_ptr;
    logic [3:0] r_addr;
    logic [4:0] r_count;

    int n_chk;
    int n_fail;

    // Model state after the most recent edge. The write pointer is held in binary.
    int m_bin;
    int m_wbin;
    int m_cnt;
    bit m_empty;
    bit m_aempty;

    cdc_fifo_rptr_empty #(
        .ADDR_SIZE (4)
    ) dut (
        .r_clk          (r_clk),
        .r_rst_n        (r_rst_n),
        .r_inc          (r_inc),
        .r_q2_wptr      (r_q2_wptr),
        .r_almost_empty (r_almost_empty),
        .r_empty        (r_empty),
        .r_ptr          (r_ptr),
        .r_addr         (r_addr),
        .r_count        (r_count)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int gray_of(input int b);
        return (b ^ (b >> 1)) & 31;
    endfunction

    task automatic model_reset();
        m_bin    = 0;
        m_cnt    = 0;
        m_empty  = 1'b1;
        m_aempty = 1'b1;
    endtask

    task automatic compare_model(input string tag);
        chk({tag, "_ptr"},    32'(r_ptr),          32'(gray_of(m_bin)));
        chk({tag, "_addr"},   32'(r_addr),         32'(m_bin % 16));
        chk({tag, "_count"},  32'(r_count),        32'(m_cnt));
        chk({tag, "_empty"},  32'(r_empty),        32'(m_empty));
        chk({tag, "_aempty"}, 32'(r_almost_empty), 32'(m_aempty));
    endtask

    // Drive one cycle and advance the model. Compare on the following falling edge.
    task automatic cycle(input bit inc, input int wb, input string tag);
        bit pop;
        r_inc     = inc;
        m_wbin    = wb & 31;
        r_q2_wptr = 5'(gray_of(m_wbin));
        pop       = inc && !m_empty;
        m_bin     = (m_bin + int'(pop)) % 32;
        m_cnt     = (m_wbin - m_bin + 32) % 32;
        m_empty   = (m_cnt == 0);
        m_aempty  = (m_cnt <= 1);
        @(negedge r_clk);
        compare_model(tag);
        $display("cyc %s inc=%0d wptr=%b ptr=%b addr=%0d cnt=%0d e=%0d ae=%0d",
                 tag, inc, r_q2_wptr, r_ptr, r_addr, r_count, r_empty, r_almost_empty);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ptr"},    32'(r_ptr),          32'd0);
        chk({tag, "_addr"},   32'(r_addr),         32'd0);
        chk({tag, "_count"},  32'(r_count),        32'd0);
        chk({tag, "_empty"},  32'(r_empty),        32'd1);
        chk({tag, "_aempty"}, 32'(r_almost_empty), 32'd1);
    endtask

    initial begin
        logic [4:0] prev_ptr;
        n_chk     = 0;
        n_fail    = 0;
        r_rst_n   = 1'b0;
        r_inc     = 1'b0;
        r_q2_wptr = '0;
        m_wbin    = 0;
        model_reset();
        #12;
        chk_reset_vals("reset");
        @(negedge r_clk);
        r_rst_n = 1'b1;

        // 1: popping an empty FIFO must not move the pointer.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 0, "t1");
            chk_reset_vals("t1_lit");
        end

        // 2: four words become visible.
        cycle(1'b0, 4, "t2");
        chk("t2_count_lit", 32'(r_count), 32'd4);
        chk("t2_empty_lit", 32'(r_empty), 32'd0);
        chk("t2_aempty_lit", 32'(r_almost_empty), 32'd0);

        // 3: three pops.
        for (int i = 0; i < 3; i++) cycle(1'b1, 4, "t3");
        chk("t3_addr_lit", 32'(r_addr), 32'd3);
        chk("t3_ptr_lit", 32'(r_ptr), 32'b00010);
        chk("t3_count_lit", 32'(r_count), 32'd1);
        chk("t3_aempty_lit", 32'(r_almost_empty), 32'd1);
        chk("t3_empty_lit", 32'(r_empty), 32'd0);

        // 4: the last pop empties the FIFO, and further pops are ignored.
        cycle(1'b1, 4, "t4");
        chk("t4_empty_lit", 32'(r_empty), 32'd1);
        chk("t4_ptr_lit", 32'(r_ptr), 32'b00110);
        chk("t4_addr_lit", 32'(r_addr), 32'd4);
        chk("t4_count_lit", 32'(r_count), 32'd0);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 4, "t4b");
            chk("t4b_ptr_lit", 32'(r_ptr), 32'b00110);
            chk("t4b_addr_lit", 32'(r_addr), 32'd4);
            chk("t4b_empty_lit", 32'(r_empty), 32'd1);
        end

        // 5: the address wraps, and the pointer ends at the wrapped Gray code.
        cycle(1'b0, 16, "t5a");
        chk("t5_count12_lit", 32'(r_count), 32'd12);
        for (int k = 0; k < 12; k++) begin
            prev_ptr = r_ptr;
            cycle(1'b1, 16, "t5");
            chk("t5_onebit", 32'($countones(prev_ptr ^ r_ptr)), 32'd1);
            chk("t5_count_lit", 32'(r_count), 32'(11 - k));
            if (k == 11) chk("t5_addr_wrap_lit", 32'(r_addr), 32'd0);
        end
        chk("t5_ptr_lit", 32'(r_ptr), 32'b11000);
        chk("t5_empty_lit", 32'(r_empty), 32'd1);

        // 6: asynchronous reset between edges.
        cycle(1'b0, 18, "t6a");
        chk("t6_count2_lit", 32'(r_count), 32'd2);
        #2 r_rst_n = 1'b0;
        #1 chk_reset_vals("t6_async");
        r_q2_wptr = '0;
        m_wbin    = 0;
        model_reset();
        @(negedge r_clk);
        r_rst_n = 1'b1;
        cycle(1'b0, 0, "t6b");
        chk("t6_empty_lit", 32'(r_empty), 32'd1);

        // Random traffic. The write side never runs more than one FIFO depth ahead.
        for (int i = 0; i < 3000; i++) begin
            int occ;
            int adv;
            bit inc;
            bit write_heavy;
            write_heavy = ((i / 300) % 2) == 0;
            occ = (m_wbin - m_bin + 32) % 32;
            adv = write_heavy ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 3) == 0);
            if (occ + adv > 16) adv = 16 - occ;
            inc = write_heavy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            cycle(inc, m_wbin + adv, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
